// File: rtl/timer_poll_ctrl.sv
// timer_poll_ctrl: drives an interval-timer device through program / arm /
// poll / acknowledge cycles. It emits a tick pulse per expiry, an optional
// done pulse at the end of a run, and a running expiry count.
module timer_poll_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               GWE,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [15:0]        interval_cfg,
  input  logic [COUNT_W-1:0] tick_limit,
  output logic               write_interval,
  output logic [15:0]        interval_out,
  output logic               read_status,
  input  logic               status_in,
  output logic               busy,
  output logic               tick,
  output logic               done,
  output logic [COUNT_W-1:0] tick_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_EXPIRE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic               per_q, per_d;
  logic [15:0]        ival_q, ival_d;
  logic [COUNT_W-1:0] lim_q, lim_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] cnt_inc;

  // Count after the current expiry is accounted for; wraps naturally.
  assign cnt_inc = cnt_q + COUNT_W'(1);

  // Next-state and run-configuration latch logic.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    ival_d  = ival_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      // start together with stop is treated as "do nothing".
      if (start && !stop) begin
        per_d   = periodic;
        ival_d  = interval_cfg;
        lim_d   = tick_limit;
        cnt_d   = '0;
        state_d = S_LOAD;
      end
    end else if (stop) begin
      // Abort wins over every other transition; count is left untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_LOAD:   state_d = S_ARM;
        S_ARM:    if (status_in) state_d = S_WAIT;
        S_WAIT:   if (status_in) state_d = S_EXPIRE;
        S_EXPIRE: begin
          cnt_d = cnt_inc;
          if (!per_q)                              state_d = S_DONE;
          else if (lim_q != '0 && cnt_inc == lim_q) state_d = S_DONE;
          else                                     state_d = S_WAIT;
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset dominates, GWE freezes everything else.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      per_q   <= 1'b0;
      ival_q  <= '0;
      lim_q   <= '0;
      cnt_q   <= '0;
    end else if (GWE) begin
      state_q <= state_d;
      per_q   <= per_d;
      ival_q  <= ival_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode. In periodic EXPIRE the status read doubles as the
  // reload acknowledge; in one-shot the timer is left expired on purpose.
  always_comb begin
    busy           = (state_q != S_IDLE);
    write_interval = (state_q == S_LOAD);
    read_status    = (state_q == S_ARM) || (state_q == S_EXPIRE && per_q);
    tick           = (state_q == S_EXPIRE);
    done           = (state_q == S_DONE);
  end

  assign interval_out = ival_q;
  assign tick_count   = cnt_q;

endmodule

// File: tb/tb_timer_poll_ctrl.sv
// Bench for timer_poll_ctrl: a small interval-timer stub answers the
// controller, and run results are compared with tick timing derived from the
// reload rule (first tick L+2 after leaving ARM, then every L+3 cycles).
module tb_timer_poll_ctrl;

  localparam int COUNT_W = 16;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               GWE = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               periodic = 1'b0;
  logic [15:0]        interval_cfg = '0;
  logic [COUNT_W-1:0] tick_limit = '0;
  logic               write_interval;
  logic [15:0]        interval_out;
  logic               read_status;
  logic               status_in;
  logic               busy, tick, done;
  logic [COUNT_W-1:0] tick_count;

  int n_chk  = 0;
  int n_fail = 0;

  timer_poll_ctrl #(.COUNT_W(COUNT_W)) dut (
    .CLK(CLK), .RST(RST), .GWE(GWE), .start(start), .stop(stop),
    .periodic(periodic), .interval_cfg(interval_cfg), .tick_limit(tick_limit),
    .write_interval(write_interval), .interval_out(interval_out),
    .read_status(read_status), .status_in(status_in), .busy(busy),
    .tick(tick), .done(done), .tick_count(tick_count)
  );

  always #5 CLK = ~CLK;

  // Interval-timer stub: a read while expired reloads I*8192 and clears the
  // status; otherwise it counts down and raises status at zero.
  logic [15:0] t_ival;
  int unsigned t_cnt;
  logic        t_st;
  always @(posedge CLK) begin
    if (RST) begin
      t_st <= 1'b0; t_cnt <= 0; t_ival <= '0;
    end else if (GWE) begin
      if (write_interval) begin
        t_ival <= interval_out; t_cnt <= 0;
      end else if (read_status && t_st) begin
        t_st <= 1'b0; t_cnt <= 32'(t_ival) * 8192;
      end else if (t_cnt == 0) t_st <= 1'b1;
      else t_cnt <= t_cnt - 1;
    end
  end
  assign status_in = t_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " outs"}, {27'd0, busy, tick, done, write_interval, read_status}, 0);
    chk({tag, " cnt"}, 32'(tick_count), 0);
  endtask

  // One run from IDLE to IDLE; stop_after>0 aborts in WAIT after that many ticks.
  task automatic do_run(input int iv, input bit per, input int lim,
                        input int stop_after, input string tag);
    int c, arm_leave, nwr, ndone, dn_c, exp_ticks, ell;
    bit seen_rd, prev_tick, natural;
    logic [15:0] wr_val;
    int tk[$];
    int tcs[$];
    c = 0; arm_leave = -1; nwr = 0; ndone = 0; dn_c = -1;
    seen_rd = 0; prev_tick = 0; wr_val = '0;
    ell = iv * 8192;
    interval_cfg = 16'(iv); periodic = per; tick_limit = COUNT_W'(lim);
    start = 1'b1; cyc(); start = 1'b0;
    while (busy && c < 60000) begin
      if (write_interval) begin nwr++; wr_val = interval_out; end
      if (read_status) seen_rd = 1;
      else if (seen_rd && arm_leave < 0) arm_leave = c;
      if (tick) tk.push_back(c);
      if (prev_tick) tcs.push_back(int'(tick_count));
      prev_tick = tick;
      if (done) begin ndone++; dn_c = c; end
      if (stop_after > 0 && tk.size() == stop_after && !tick) stop = 1'b1;
      cyc(); c++;
    end
    stop = 1'b0;
    chk({tag, " finished"}, {31'd0, busy}, 0);
    natural   = !(per && lim == 0);
    exp_ticks = !per ? 1 : (lim != 0 ? lim : stop_after);
    chk({tag, " writes"}, nwr, 1);
    chk({tag, " intv"}, 32'(wr_val), iv);
    chk({tag, " ticks"}, tk.size(), exp_ticks);
    for (int k = 0; k < tk.size(); k++)
      chk($sformatf("%s tick%0d time", tag, k), tk[k],
          (k == 0) ? arm_leave + ell + 2 : tk[k-1] + ell + 3);
    for (int k = 0; k < tcs.size(); k++)
      chk($sformatf("%s count%0d", tag, k), tcs[k], k + 1);
    chk({tag, " final cnt"}, 32'(tick_count), exp_ticks);
    chk({tag, " dones"}, ndone, natural ? 1 : 0);
    if (natural && tk.size() > 0) begin
      chk({tag, " done time"}, dn_c, tk[tk.size()-1] + 1);
      chk({tag, " idle time"}, c, dn_c + 1);
    end
    if (!per) chk({tag, " status left set"}, {31'd0, status_in}, 1);
  endtask

  initial begin
    int ticks, guard, tc0, gap;
    bit per;
    int lim, sa;

    // Reset, then idle with start low.
    RST = 1'b1; cyc(); cyc(); RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk_idle("reset idle");
      chk("reset intv", 32'(interval_out), 0);
    end

    do_run(1, 1'b0, 0, 0, "oneshot I1");
    do_run(0, 1'b1, 4, 0, "periodic I0 lim4");
    do_run(2, 1'b1, 0, 3, "periodic I2 free");

    // Stop in WAIT after two ticks.
    interval_cfg = 16'd0; periodic = 1'b1; tick_limit = '0;
    start = 1'b1; cyc(); start = 1'b0;
    ticks = 0; guard = 0;
    while (!(ticks == 2 && !tick) && guard < 200) begin
      if (tick) ticks++;
      cyc(); guard++;
    end
    chk("stop reached WAIT", {30'd0, busy, read_status}, 2);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop busy", {29'd0, busy, tick, done}, 0);
    chk("stop cnt", 32'(tick_count), 2);
    // start and stop together in IDLE: nothing happens.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("start+stop busy", {30'd0, busy, write_interval}, 0);
    cyc();
    chk("start+stop still idle", {31'd0, busy}, 0);

    // Randomized short runs with a zero interval.
    for (int r = 0; r < 8; r++) begin
      per = 1'($urandom_range(0, 1));
      lim = int'($urandom_range(0, 5));
      sa  = (per && lim == 0) ? int'($urandom_range(1, 4)) : 0;
      gap = int'($urandom_range(0, 3));
      repeat (gap) cyc();
      do_run(0, per, lim, sa, $sformatf("rnd%0d p%0d l%0d", r, per, lim));
    end

    // GWE low during EXPIRE stretches tick; count steps once.
    interval_cfg = 16'd0; periodic = 1'b1; tick_limit = '0;
    start = 1'b1; cyc(); start = 1'b0;
    guard = 0;
    while (!tick && guard < 100) begin cyc(); guard++; end
    chk("gwe tick seen", {31'd0, tick}, 1);
    tc0 = int'(tick_count);
    GWE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("gwe hold tick%0d", i), {31'd0, tick}, 1);
      chk($sformatf("gwe hold cnt%0d", i), 32'(tick_count), tc0);
    end
    GWE = 1'b1; cyc();
    chk("gwe release tick", {31'd0, tick}, 0);
    chk("gwe release cnt", 32'(tick_count), tc0 + 1);
    chk("gwe in WAIT", {30'd0, busy, read_status}, 2);
    // Reset while in WAIT.
    RST = 1'b1; cyc(); RST = 1'b0;
    chk_idle("mid reset");
    chk("mid reset intv", 32'(interval_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
